// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler.
//   BYTE_W   : width of one transmitted byte
//   RETRY_W  : width of the saturating start re-pulse counter
//   state_t  : scheduler FSM states
//   sat_inc  : saturating increment for the retry counter
package uart_pkg;

    localparam int BYTE_W  = 8;
    localparam int RETRY_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_LAUNCH,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    function automatic logic [RETRY_W-1:0] sat_inc(input logic [RETRY_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Byte-producer and transmitter signals of the UART transmit scheduler.
//   req_valid / req_data / req_last : producer byte offers (byte i at [8i+7:8i])
//   req_ready                       : one-hot single-cycle accept strobe
//   tx_data / tx_start              : byte and start pulse to the transmitter
//   tx_busy                         : transmitter busy flag
// master: producers + transmitter side, slave: the scheduler.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 4
);
    import uart_pkg::*;

    logic [NUM_REQ-1:0]        req_valid;
    logic [BYTE_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic [BYTE_W-1:0]         tx_data;
    logic                      tx_start;
    logic                      tx_busy;

    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_start
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_start
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority selector.
//   req   : request vector
//   last  : index granted most recently
//   found : at least one request is set
//   idx   : first set request searching upward from last+1, wrapping;
//           last itself has the lowest priority
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int c;

    // Walk candidates from lowest to highest priority so the highest
    // priority match is the final assignment.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            c = (int'(last) + i) % NUM_REQ;
            if (req[c[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = c[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte
// producers, with packet lock bounded by MAX_BURST and start re-pulsing
// when the transmitter does not go busy within BUSY_TIMEOUT cycles.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : producer handshake + transmitter signals (slave side)
//   grant_id   : index of the current or last grantee
//   active     : high from accept until the frame completes
//   retry_cnt  : saturating count of start re-pulses
//
// state       | meaning
// S_IDLE      | choose next requester (locked one or round-robin)
// S_ACCEPT    | req_ready strobe, byte captured at the end of the cycle
// S_LAUNCH    | tx_start pulse, busy timeout armed
// S_WAIT_BUSY | wait for tx_busy to rise, re-launch on timeout
// S_WAIT_DONE | wait for tx_busy to fall, update lock/burst
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int IDX_W        = 2,
    parameter int MAX_BURST    = 16,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_sched_if.slave      bus,
    output logic [IDX_W-1:0]    grant_id,
    output logic                active,
    output logic [RETRY_W-1:0]  retry_cnt
);

    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam int TMR_W   = $clog2(BUSY_TIMEOUT + 1);

    state_t               state;
    logic [NUM_REQ-1:0]   req_ready;
    logic [BYTE_W-1:0]    tx_data;
    logic                 tx_start;
    logic                 last_q;
    logic                 lock;
    logic [BURST_W-1:0]   burst;
    logic [TMR_W-1:0]     tmr;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;
    logic [BYTE_W-1:0]    sel_byte;
    logic                 nxt_lock;

    assign bus.req_ready = req_ready;
    assign bus.tx_data   = tx_data;
    assign bus.tx_start  = tx_start;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (bus.req_valid),
        .last  (grant_id),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == IDX_W'(i))
                sel_byte = bus.req_data[i*BYTE_W +: BYTE_W];
        end
    end

    // Keep the grant only for a non-final byte while the burst cap allows it.
    assign nxt_lock = !last_q && ((int'(burst) + 1) < MAX_BURST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            req_ready <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            grant_id  <= '0;
            active    <= 1'b0;
            retry_cnt <= '0;
            last_q    <= 1'b0;
            lock      <= 1'b0;
            burst     <= '0;
            tmr       <= '0;
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Never start a transmitter that is already busy.
                    if (!bus.tx_busy) begin
                        if (lock) begin
                            if (bus.req_valid[grant_id]) begin
                                req_ready <= NUM_REQ'(1) << grant_id;
                                active    <= 1'b1;
                                state     <= S_ACCEPT;
                            end
                        end else if (pick_found) begin
                            grant_id  <= pick_idx;
                            req_ready <= NUM_REQ'(1) << pick_idx;
                            active    <= 1'b1;
                            state     <= S_ACCEPT;
                        end
                    end
                end
                S_ACCEPT: begin
                    tx_data  <= sel_byte;
                    last_q   <= bus.req_last[grant_id];
                    tx_start <= 1'b1;
                    state    <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    tmr   <= TMR_W'(BUSY_TIMEOUT - 1);
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (bus.tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (tmr == '0) begin
                        tx_start  <= 1'b1;
                        retry_cnt <= sat_inc(retry_cnt);
                        state     <= S_LAUNCH;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        active <= 1'b0;
                        lock   <= nxt_lock;
                        burst  <= nxt_lock ? burst + 1'b1 : '0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    localparam int NR = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant_id;
    logic       active;
    logic [7:0] retry_cnt;

    always #5 clk = ~clk;

    uart_tx_sched_if #(.NUM_REQ(NR)) bus();

    uart_tx_sched #(
        .NUM_REQ      (NR),
        .IDX_W        (2),
        .MAX_BURST    (16),
        .BUSY_TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .grant_id  (grant_id),
        .active    (active),
        .retry_cnt (retry_cnt)
    );

    // producer model: requester i offers bytes dbase+n while n < limit
    int         sent[NR]    = '{default: 0};
    int         base[NR]    = '{default: 0};
    int         limit[NR]   = '{default: 0};
    int         pkt_len[NR] = '{default: 1};
    logic [7:0] dbase[NR]   = '{default: 8'h00};

    logic [NR-1:0]   pv;
    logic [8*NR-1:0] pd;
    logic [NR-1:0]   pl;
    int              n;

    always_comb begin
        pv = '0;
        pd = '0;
        pl = '0;
        n  = 0;
        for (int i = 0; i < NR; i++) begin
            n = sent[i] - base[i];
            if (n < limit[i]) pv[i] = 1'b1;
            pd[i*8 +: 8] = dbase[i] + 8'(n);
            if (pkt_len[i] != 0 && (n % pkt_len[i]) == pkt_len[i] - 1) pl[i] = 1'b1;
        end
    end

    // transmitter model: busy for 10 cycles starting the cycle after tx_start
    logic auto_en  = 1'b1;
    logic man_busy = 1'b0;
    int   busy_cnt = 0;

    always @(posedge clk) begin
        if (!auto_en || reset) busy_cnt <= 0;
        else if (bus.tx_start) busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    assign bus.req_valid = pv;
    assign bus.req_data  = pd;
    assign bus.req_last  = pl;
    assign bus.tx_busy   = auto_en ? (busy_cnt != 0) : man_busy;

    // monitor: accept order, launched bytes, start pulses
    int         acc_q[$];
    logic [7:0] txd_q[$];
    int         start_cnt = 0;
    int         viol = 0;
    bit         pend = 0;
    int         pend_idx = 0;

    always @(negedge clk) begin
        if (reset) begin
            pend = 0;
        end else begin
            if (pend) begin
                sent[pend_idx] = sent[pend_idx] + 1;
                txd_q.push_back(bus.tx_data);
                pend = 0;
            end
            if (bus.req_ready != '0) begin
                for (int i = 0; i < NR; i++)
                    if (bus.req_ready[i]) pend_idx = i;
                pend = 1;
                acc_q.push_back(pend_idx);
            end
            if (bus.tx_start) start_cnt = start_cnt + 1;
            if (bus.tx_start && bus.tx_busy) viol = viol + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        int k;
        k = 0;
        while ((active !== 1'b0 || bus.tx_busy !== 1'b0) && k < 400) begin
            step();
            k++;
        end
        ok = (k < 400);
    endtask

    task automatic wait_accepts(input int target, input int budget, output bit ok);
        int k;
        k = 0;
        while (acc_q.size() < target && k < budget) begin
            step();
            k++;
        end
        ok = (acc_q.size() >= target);
    endtask

    task automatic test_reset();
        step();
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready got=%b want=0000", bus.req_ready); end
        total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b want=0", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rst_data got=%h want=00", bus.tx_data); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant got=%0d want=0", grant_id); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rst_active got=%b want=0", active); end
        total++; if (retry_cnt !== 8'd0) begin bad++; $display("FAIL rst_retry got=%0d want=0", retry_cnt); end
        reset = 1'b0;
        step();
        step();
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rst_idle_ready got=%b want=0000", bus.req_ready); end
    endtask

    task automatic test_single();
        int k;
        base[0] = sent[0]; dbase[0] = 8'h55; pkt_len[0] = 1; limit[0] = 1;
        step();
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", bus.req_ready); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL single_active_on got=%b want=1", active); end
        step();
        total++; if (bus.tx_start !== 1'b1) begin bad++; $display("FAIL single_start got=%b want=1", bus.tx_start); end
        total++; if (bus.tx_data !== 8'h55) begin bad++; $display("FAIL single_data got=%h want=55", bus.tx_data); end
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_off got=%b want=0000", bus.req_ready); end
        k = 0;
        while (bus.tx_busy !== 1'b1 && k < 5) begin step(); k++; end
        while (bus.tx_busy !== 1'b0 && k < 40) begin step(); k++; end
        total++; if (k >= 40) begin bad++; $display("FAIL single_frame timeout cycles=%0d want<40", k); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL single_active_hold got=%b want=1", active); end
        step();
        total++; if (active !== 1'b0) begin bad++; $display("FAIL single_active_drop got=%b want=0", active); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_grant got=%0d want=0", grant_id); end
    endtask

    task automatic test_contention();
        int         n0, s0;
        bit         ok;
        int         exp_idx[5] = '{1, 2, 3, 0, 1};
        logic [7:0] exp_dat[5] = '{8'hB0, 8'hC0, 8'hD0, 8'hA0, 8'hB1};
        n0 = acc_q.size();
        s0 = start_cnt;
        for (int i = 0; i < NR; i++) begin
            base[i] = sent[i]; dbase[i] = 8'hA0 + 8'(i * 16); pkt_len[i] = 1; limit[i] = 100;
        end
        wait_accepts(n0 + 5, 200, ok);
        for (int i = 0; i < NR; i++) limit[i] = 0;
        total++; if (!ok) begin bad++; $display("FAIL cont_accepts got=%0d want=5", acc_q.size() - n0); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL cont_idle timeout active=%b", active); end
        for (int k = 0; k < 5; k++) begin
            if (acc_q.size() > n0 + k && txd_q.size() > n0 + k) begin
                total++; if (acc_q[n0+k] != exp_idx[k]) begin bad++; $display("FAIL cont_order[%0d] got=%0d want=%0d", k, acc_q[n0+k], exp_idx[k]); end
                total++; if (txd_q[n0+k] !== exp_dat[k]) begin bad++; $display("FAIL cont_data[%0d] got=%h want=%h", k, txd_q[n0+k], exp_dat[k]); end
            end
        end
        total++; if (start_cnt - s0 != 5) begin bad++; $display("FAIL cont_starts got=%0d want=5", start_cnt - s0); end
        total++; if (acc_q.size() - n0 != 5) begin bad++; $display("FAIL cont_count got=%0d want=5", acc_q.size() - n0); end
    endtask

    task automatic test_packet_lock();
        int         n0;
        bit         ok;
        int         exp_idx[4] = '{2, 2, 2, 0};
        logic [7:0] exp_dat[4] = '{8'h20, 8'h21, 8'h22, 8'h01};
        n0 = acc_q.size();
        base[2] = sent[2]; dbase[2] = 8'h20; pkt_len[2] = 3; limit[2] = 3;
        base[0] = sent[0]; dbase[0] = 8'h01; pkt_len[0] = 1; limit[0] = 1;
        wait_accepts(n0 + 4, 200, ok);
        total++; if (!ok) begin bad++; $display("FAIL lock_accepts got=%0d want=4", acc_q.size() - n0); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL lock_idle timeout active=%b", active); end
        for (int k = 0; k < 4; k++) begin
            if (acc_q.size() > n0 + k && txd_q.size() > n0 + k) begin
                total++; if (acc_q[n0+k] != exp_idx[k]) begin bad++; $display("FAIL lock_order[%0d] got=%0d want=%0d", k, acc_q[n0+k], exp_idx[k]); end
                total++; if (txd_q[n0+k] !== exp_dat[k]) begin bad++; $display("FAIL lock_data[%0d] got=%h want=%h", k, txd_q[n0+k], exp_dat[k]); end
            end
        end
    endtask

    task automatic test_burst_cap();
        int n0, exp_i;
        bit ok;
        n0 = acc_q.size();
        base[1] = sent[1]; dbase[1] = 8'h40; pkt_len[1] = 0; limit[1] = 20;
        base[3] = sent[3]; dbase[3] = 8'h90; pkt_len[3] = 1; limit[3] = 1;
        wait_accepts(n0 + 21, 800, ok);
        total++; if (!ok) begin bad++; $display("FAIL burst_accepts got=%0d want=21", acc_q.size() - n0); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL burst_idle timeout active=%b", active); end
        if (acc_q.size() >= n0 + 21 && txd_q.size() >= n0 + 21) begin
            for (int k = 0; k < 21; k++) begin
                exp_i = (k == 16) ? 3 : 1;
                total++; if (acc_q[n0+k] != exp_i) begin bad++; $display("FAIL burst_order[%0d] got=%0d want=%0d", k, acc_q[n0+k], exp_i); end
            end
            total++; if (txd_q[n0+15] !== 8'h4F) begin bad++; $display("FAIL burst_data15 got=%h want=4F", txd_q[n0+15]); end
            total++; if (txd_q[n0+16] !== 8'h90) begin bad++; $display("FAIL burst_data16 got=%h want=90", txd_q[n0+16]); end
            total++; if (txd_q[n0+17] !== 8'h50) begin bad++; $display("FAIL burst_data17 got=%h want=50", txd_q[n0+17]); end
            total++; if (txd_q[n0+20] !== 8'h53) begin bad++; $display("FAIL burst_data20 got=%h want=53", txd_q[n0+20]); end
        end
    endtask

    task automatic test_busy_timeout();
        int k, s0;
        bit ok;
        auto_en = 1'b0; man_busy = 1'b0;
        base[1] = sent[1]; dbase[1] = 8'h7E; pkt_len[1] = 1; limit[1] = 1;
        k = 0;
        while (bus.tx_start !== 1'b1 && k < 10) begin step(); k++; end
        total++; if (k >= 10) begin bad++; $display("FAIL tmo_first_start timeout cycles=%0d", k); end
        s0 = start_cnt;
        total++; if (bus.tx_data !== 8'h7E) begin bad++; $display("FAIL tmo_data got=%h want=7E", bus.tx_data); end
        total++; if (grant_id !== 2'd1) begin bad++; $display("FAIL tmo_grant got=%0d want=1", grant_id); end
        for (int r = 1; r <= 3; r++) begin
            k = 0;
            do begin step(); k++; end while (bus.tx_start !== 1'b1 && k < 20);
            total++; if (k != 5) begin bad++; $display("FAIL tmo_period[%0d] got=%0d want=5", r, k); end
            total++; if (retry_cnt !== 8'(r)) begin bad++; $display("FAIL tmo_retry[%0d] got=%0d want=%0d", r, retry_cnt, r); end
        end
        step();
        man_busy = 1'b1;
        step(); step(); step();
        man_busy = 1'b0;
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL tmo_idle timeout active=%b", active); end
        total++; if (retry_cnt !== 8'd3) begin bad++; $display("FAIL tmo_retry_final got=%0d want=3", retry_cnt); end
        total++; if (start_cnt - s0 != 3) begin bad++; $display("FAIL tmo_restarts got=%0d want=3", start_cnt - s0); end
        auto_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int  k, s0, n0;
        bit  ok;
        base[2] = sent[2]; dbase[2] = 8'h3C; pkt_len[2] = 1; limit[2] = 1;
        k = 0;
        while (bus.tx_busy !== 1'b1 && k < 20) begin step(); k++; end
        step(); step();
        total++; if (active !== 1'b1) begin bad++; $display("FAIL rmid_pre_active got=%b want=1", active); end
        auto_en = 1'b0; man_busy = 1'b0;
        reset = 1'b1;
        #1;
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rmid_active got=%b want=0", active); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rmid_grant got=%0d want=0", grant_id); end
        total++; if (bus.tx_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want=00", bus.tx_data); end
        total++; if (retry_cnt !== 8'd0) begin bad++; $display("FAIL rmid_retry got=%0d want=0", retry_cnt); end
        total++; if (bus.tx_start !== 1'b0 || bus.req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_strobes got=%b/%b want=0/0000", bus.tx_start, bus.req_ready); end
        step(); step();
        s0 = start_cnt; n0 = acc_q.size();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) step();
        total++; if (start_cnt != s0 || acc_q.size() != n0) begin bad++; $display("FAIL rmid_quiet got=%0d/%0d want=0/0", start_cnt - s0, acc_q.size() - n0); end
        man_busy = 1'b1;
        base[3] = sent[3]; dbase[3] = 8'hC3; pkt_len[3] = 1; limit[3] = 1;
        for (int i = 0; i < 5; i++) step();
        total++; if (start_cnt != s0 || acc_q.size() != n0) begin bad++; $display("FAIL rmid_busy_block got=%0d/%0d want=0/0", start_cnt - s0, acc_q.size() - n0); end
        man_busy = 1'b0; auto_en = 1'b1;
        step();
        total++; if (bus.req_ready !== 4'b1000) begin bad++; $display("FAIL rmid_ready got=%b want=1000", bus.req_ready); end
        wait_idle(ok);
        total++; if (!ok) begin bad++; $display("FAIL rmid_idle timeout active=%b", active); end
        total++; if (txd_q.size() == 0 || txd_q[txd_q.size()-1] !== 8'hC3) begin bad++; $display("FAIL rmid_data_sent got=%h want=C3", (txd_q.size() == 0) ? 8'h00 : txd_q[txd_q.size()-1]); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_packet_lock();
        test_burst_cap();
        test_busy_timeout();
        test_reset_mid();
        total++; if (viol != 0) begin bad++; $display("FAIL start_while_busy got=%0d want=0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares the single UART transmitter among NUM_REQ byte producers (command echo, status reporter, debug dump, etc.).
- Accepts one byte at a time from a requester through a valid/ready handshake.
- Drives the transmitter's data/start inputs and tracks its busy output to sequence back-to-back frames.
- Supports packet lock: a requester keeps the grant until it sends a byte with last=1, bounded by MAX_BURST.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, grant index width; must equal clog2(NUM_REQ).
- MAX_BURST, 16, maximum bytes per grant before a forced re-arbitration.
- BUSY_TIMEOUT, 4, cycles to wait for tx_busy to rise after tx_start before re-pulsing.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  8*NUM_REQ  byte of requester i at [8i+7:8i]
- req_last  in  NUM_REQ  byte ends the requester's packet
- req_ready  out  NUM_REQ  one-hot, single-cycle accept strobe
- tx_data  out  8  byte to the transmitter
- tx_start  out  1  single-cycle start pulse to the transmitter
- tx_busy  in  1  transmitter busy flag
- grant_id  out  IDX_W  index of the current or last grantee
- active  out  1  high from accept until the frame completes
- retry_cnt  out  8  saturating count of start re-pulses

Behaviour:
- Reset (asynchronous):
  - State IDLE.
  - req_ready=0, tx_start=0, tx_data=0, grant_id=0, active=0, retry_cnt=0.
  - Round-robin pointer=0, lock=0, burst count=0.
  - Reset may arrive in any state. No pulse may leak out of it.
- FSM states: IDLE, ACCEPT, LAUNCH, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Stay while tx_busy=1. An externally busy transmitter is never started.
  - Otherwise, if lock=1 and req_valid[grant_id]=1, select grant_id.
  - Otherwise, if lock=0, select the first valid requester searching from (grant_id+1) mod NUM_REQ upward with wrap.
  - Whenever a requester is selected, go to ACCEPT.
  - If lock=1 and the locked requester is not valid, wait; other requesters are not served.
- ACCEPT (1 cycle):
  - req_ready[sel]=1.
  - Capture req_data and req_last into tx_data and the last flag.
  - grant_id=sel, active=1.
- LAUNCH (1 cycle):
  - tx_start=1.
  - Start the timeout counter.
- WAIT_BUSY:
  - On tx_busy=1, go to WAIT_DONE.
  - If BUSY_TIMEOUT cycles elapse without tx_busy, return to LAUNCH and increment retry_cnt (saturating at 255).
- WAIT_DONE:
  - On tx_busy=0, active=0 and update burst/lock:
    - lock = !last && (burst+1 < MAX_BURST).
    - burst = lock ? burst+1 : 0.
  - Then go to IDLE.
- Latency: valid with the transmitter idle produces req_ready 1 cycle later (registered). tx_start follows 1 cycle after req_ready.
- tx_data is held stable from ACCEPT until the next ACCEPT.
- The byte presented in the cycle req_ready=1 is the one transmitted. A requester may drop valid before acceptance without effect.
- Simultaneous valids are served strictly round-robin. No requester waits more than NUM_REQ-1 foreign grants (excluding locked bursts).
- The grant_id pointer wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum.
  - BYTE_W=8.
  - Retry counter width.
- One natural sub-module: rr_pick.
  - Combinational round-robin priority selector.
  - Inputs: request vector, last grant index.
  - Outputs: found flag, selected index.
  - Reusable by future RX-side distributors.

Test Plan:
- Single request: req_valid=0001, data 0x55, last=1, tx_busy mimics 10-bit frame.
  - Expect req_ready=0001 1 cycle after valid, tx_start 1 cycle later, tx_data=0x55.
  - Expect active to drop the cycle after tx_busy falls; grant_id=0.
- Contention: all four valid continuously with last=1, grant_id starting at 0.
  - Expect accept order 1,2,3,0,1…
  - Expect exactly one tx_start per frame, never while tx_busy=1.
- Packet lock: requester 2 sends 3 bytes (last=0,0,1) while requester 0 is valid.
  - Expect all three bytes from 2 consecutively, then 0.
- MAX_BURST=16 cap: requester 1 holds last=0 for 20 bytes while requester 3 is valid.
  - Expect a switch to 3 after 16 bytes, then a return to 1.
- Busy timeout: tx_busy stuck at 0 after start.
  - Expect tx_start re-pulse every BUSY_TIMEOUT+1 cycles, retry_cnt incrementing.
  - Releasing tx_busy completes the frame normally.
- Reset mid-frame: assert reset in WAIT_DONE.
  - Expect all outputs 0 immediately and no tx_start after release until a new valid.
  - Expect an external tx_busy=1 at release to block the launch.
